// File: rtl/dm_arbiter_pkg.sv
// Shared datapath constants plus the data-memory arbiter's read FSM encoding.
// Widths here are the defaults for the 8-bit accumulator datapath.
package dm_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;

  // Forced-grant threshold for the external port; legal range 1..15.
  localparam int MAX_WAIT_DEF = 4;
  localparam int WAIT_CNT_W   = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_DONE = 1'b1
  } rd_state_t;

  function automatic logic [WAIT_CNT_W-1:0] wait_limit(input int max_wait);
    return WAIT_CNT_W'(max_wait);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating wait counter for a pending external request; clear wins over increment.
// at_limit is combinational from the registered count.
module arb_wait_counter
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic nReset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = wait_limit(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: core has priority, external port forced in after MAX_WAIT cycles.
// Grant and stall are combinational; external read data returns one cycle after grant.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  CoreAcc,
  input  logic                  CoreWE,
  input  logic [ADDR_WIDTH-1:0] CoreAddr,
  input  logic [DATA_WIDTH-1:0] CoreWData,
  output logic                  CoreStall,
  input  logic                  ExtReq,
  input  logic                  ExtWE,
  input  logic [ADDR_WIDTH-1:0] ExtAddr,
  input  logic [DATA_WIDTH-1:0] ExtWData,
  output logic                  ExtGnt,
  output logic                  ExtRdValid,
  output logic [DATA_WIDTH-1:0] ExtRdData,
  output logic                  MemWE,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWData,
  input  logic [DATA_WIDTH-1:0] MemRData
);

  logic      wait_at_limit;
  logic      ext_rd_gnt;
  rd_state_t state_q;
  rd_state_t state_d;

  arb_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_cnt (
    .clk     (clk),
    .nReset  (nReset),
    .clr     (ExtGnt | ~ExtReq),
    .inc     (ExtReq & ~ExtGnt),
    .at_limit(wait_at_limit)
  );

  assign ExtGnt     = ExtReq & (~CoreAcc | wait_at_limit);
  assign CoreStall  = ExtGnt & CoreAcc;
  assign ext_rd_gnt = ExtGnt & ~ExtWE;

  // A stalled core access is dropped here; the core re-issues it next cycle.
  always_comb begin
    MemWE    = CoreWE & CoreAcc;
    MemAddr  = CoreAddr;
    MemWData = CoreWData;
    if (ExtGnt) begin
      MemWE    = ExtWE;
      MemAddr  = ExtAddr;
      MemWData = ExtWData;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RD_DONE always falls back to IDLE unless a fresh read grant re-enters it.
  always_comb begin
    state_d    = IDLE;
    ExtRdValid = 1'b0;
    case (state_q)
      IDLE: begin
        if (ext_rd_gnt) state_d = RD_DONE;
      end
      RD_DONE: begin
        ExtRdValid = 1'b1;
        if (ext_rd_gnt) state_d = RD_DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ExtRdData <= '0;
    end else if (ext_rd_gnt) begin
      ExtRdData <= MemRData;
    end
  end

endmodule
